// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types, constants and segment encoder for seg_count_display
// Purpose: digit count, BCD digit type, blank pattern and active-low
//          seven-segment encoding {g,f,e,d,c,b,a}.
// Ports:   none (package).
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_encode(input bcd_t digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decade of the BCD up/down counter
// Purpose: holds one BCD digit; steps up or down with 9->0 / 0->9 wrap.
// Ports:   CLK    in  system clock
//          RST    in  synchronous active-high reset
//          CLR    in  synchronous clear (overrides step)
//          step   in  advance this digit this cycle
//          UP     in  1 = increment, 0 = decrement
//          q      out current digit value 0..9
//          carry  out digit wraps 9->0 while counting up
//          borrow out digit wraps 0->9 while counting down
module bcd_digit
  import seg_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic step,
  input  logic UP,
  output bcd_t q,
  output logic carry,
  output logic borrow
);

  assign carry  = (q == 4'd9) & step & UP;
  assign borrow = (q == 4'd0) & step & ~UP;

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      q <= 4'd0;
    end else if (step) begin
      if (UP) begin
        q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
      end else begin
        q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
      end
    end
  end

endmodule

// File: rtl/seg_count_display.sv
// rtl/seg_count_display.sv - four-digit BCD event counter with multiplexed 7-seg drive
// Purpose: counts rising transitions of CE_IN (up or down, BCD) and scans
//          the count onto a common-anode four-digit display.
// Ports:   CLK   in  system clock
//          RST   in  synchronous active-high reset
//          CE_IN in  toggling enable; each rising transition is one event
//          EN    in  count enable level
//          UP    in  count direction, 1 = up
//          CLR   in  synchronous count clear
//          COUNT out BCD count {d3,d2,d1,d0}
//          SEG   out segments {g,f,e,d,c,b,a}, active-low
//          AN    out digit anodes, active-low, AN[i] selects digit i
module seg_count_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 40000,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_IN,
  input  logic        EN,
  input  logic        UP,
  input  logic        CLR,
  output logic [15:0] COUNT,
  output logic [6:0]  SEG,
  output logic [3:0]  AN
);

  logic                  ce_d;
  logic                  tick;
  bcd_t                  digit [NUM_DIGITS];
  logic [NUM_DIGITS:0]   step;
  logic [NUM_DIGITS-1:0] carry;
  logic [NUM_DIGITS-1:0] borrow;
  logic [NUM_DIGITS-1:0] blank;
  logic [15:0]           scan_cnt;
  logic [1:0]            idx;
  logic                  unused_wrap;

  // ce_d follows CE_IN even while in reset, so a CE_IN already high at
  // reset release is treated as old level rather than a fresh edge.
  always_ff @(posedge CLK) begin
    ce_d <= CE_IN;
  end

  assign tick    = CE_IN & ~ce_d;
  assign step[0] = tick & EN;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    bcd_digit u_digit (
      .CLK    (CLK),
      .RST    (RST),
      .CLR    (CLR),
      .step   (step[gi]),
      .UP     (UP),
      .q      (digit[gi]),
      .carry  (carry[gi]),
      .borrow (borrow[gi])
    );
    assign step[gi+1] = carry[gi] | borrow[gi];
  end

  // Wrap out of the top decade (9999->0000 / 0000->9999) has no consumer.
  assign unused_wrap = step[NUM_DIGITS];

  assign COUNT = {digit[3], digit[2], digit[1], digit[0]};

  // Leading-zero blanking cascades down from the top digit; d0 always lit.
  always_comb begin
    blank = '0;
    if (BLANK_LZ) begin
      blank[3] = (digit[3] == 4'd0);
      blank[2] = blank[3] & (digit[2] == 4'd0);
      blank[1] = blank[2] & (digit[1] == 4'd0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_cnt <= 16'd0;
      idx      <= 2'd0;
      AN       <= 4'b1111;
      SEG      <= SEG_BLANK;
    end else begin
      if (scan_cnt == 16'(SCAN_DIV - 1)) begin
        scan_cnt <= 16'd0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 16'd1;
      end
      AN  <= ~(4'b0001 << idx);
      SEG <= blank[idx] ? SEG_BLANK : seg_encode(digit[idx]);
    end
  end

endmodule
